column_adder: RTL and testbench
===============================

COLUMN_ADDER -- requirements
Module: column_adder

Interface
REQ-001 SHALL have parameter size, default 4, number of elements per column.
REQ-002 SHALL have parameter cell_width, default 32, IEEE-754 single-precision element width.
REQ-003 SHALL have parameter width, default cell_width*size, packed column width.
REQ-004 SHALL have port in_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port in_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_c  input  width  product column from column_multiplier; element k = in_c[k*cell_width +: cell_width].
REQ-007 SHALL have port in_ready  input  1  upstream column valid; held until in_ack.
REQ-008 SHALL have port in_ack  output  1  one-cycle pulse on column capture.
REQ-009 SHALL have port out_ack  input  1  downstream has taken out_sum.
REQ-010 SHALL have port out_ready  output  1  out_sum valid.
REQ-011 SHALL have port out_sum  output  cell_width  floating-point sum of the column.

Function
REQ-012 SHALL instantiate one single_adder, using input_a/input_b, input_a_stb/input_b_stb, output_z_ack, rst, output_z, output_z_stb; adds performed strictly sequentially.
REQ-013 SHALL implement states s_IDLE, s_LOAD, s_ADD, s_DONE.
REQ-014 s_IDLE: out_ready=0, in_ack=0, adder rst=1; on in_ready=1, capture in_c, pulse in_ack next cycle, accumulator <= element 0, counter <= 1, go to s_LOAD.
REQ-015 s_LOAD: if counter==size go to s_DONE; else drive input_a=accumulator, input_b=element[counter], both stb=1, adder rst=0, go to s_ADD.
REQ-016 s_ADD: hold operands and stb until output_z_stb=1; then accumulator <= output_z, output_z_ack=1 for one cycle, stb=0, counter+1, back to s_LOAD.
REQ-017 Summation order SHALL be left fold: ((e0+e1)+e2)+...+e(size-1); bit-exact against this order.
REQ-018 s_DONE: out_sum=accumulator, out_ready=1, held stable until out_ack=1 sampled, then s_IDLE with out_ready=0 next cycle.
REQ-019 size==1: no adder transaction; out_sum = e0, s_DONE reached two cycles after capture.
REQ-020 in_ready while not in s_IDLE SHALL be ignored; no in_ack, captured column unchanged.
REQ-021 out_ack outside s_DONE SHALL be ignored.
REQ-022 in_ready and out_ack both high in s_DONE: exit to s_IDLE first; new column captured no earlier than the following cycle.
REQ-023 Counter SHALL be wide enough to hold value size without wrap.
REQ-024 Latency capture-to-out_ready SHALL be 2 + sum over (size-1) adds of (adder latency + 2) cycles.

Reset
REQ-025 in_reset=1 at a rising edge SHALL force s_IDLE, out_ready=0, in_ack=0, out_sum=0, accumulator=0, counter=0, stb=0, output_z_ack=0, adder rst=1.
REQ-026 Reset mid-s_ADD SHALL abort the add; the pending adder result SHALL be discarded and never appear on out_sum.
REQ-027 Reset SHALL take priority over in_ready and out_ack in the same cycle.

Configuration
REQ-028 Macro COLUMN_ADDER_ZERO_SKIP_EN, when defined, SHALL make s_LOAD skip the adder for element bits 32'h00000000 or 32'h80000000 (counter+1, accumulator unchanged, one cycle per skip).
REQ-029 With COLUMN_ADDER_ZERO_SKIP_EN defined, an all-zero-skip sum SHALL keep sign of e0 (documented deviation from IEEE signed-zero rules).
REQ-030 Without the macro, every element SHALL go through the adder, no skip logic present.

Verification
REQ-031 in_c={3F800000 x4}, in_ready=1 -> single in_ack pulse; out_ready=1, out_sum=40800000 (4.0).
REQ-032 elements e0..e3 = 3F800000,40000000,40400000,40800000 -> out_sum=41200000 (10.0); out_sum held until out_ack pulse, then out_ready=0.
REQ-033 elements 3F800000,BF800000,40000000,C0000000 -> out_sum=00000000; in_ready pulsed during s_ADD produces no in_ack.
REQ-034 in_reset=1 for one cycle during second add of REQ-032 column -> out_ready=0, out_sum=0, s_IDLE; re-send column -> 41200000.
REQ-035 size=1, e0=40490FDB -> out_sum=40490FDB, zero adder stb cycles.
REQ-036 COLUMN_ADDER_ZERO_SKIP_EN defined, elements 00000000,00000000,80000000,40400000 -> out_sum=40400000 with exactly one adder transaction; undefined -> three transactions, same result.

Source files
------------

// File: rtl/column_adder_if.sv
// Column handshake bundle between column_multiplier (master) and column_adder (slave).
// in_ready/in_ack: upstream holds in_c and in_ready until in_ack pulses; out_ready/out_ack: out_sum held until out_ack.
interface column_adder_if #(
    parameter int size       = 4,
    parameter int cell_width = 32,
    parameter int width      = cell_width * size
);
    logic [width-1:0]      in_c;
    logic                  in_ready;
    logic                  in_ack;
    logic                  out_ack;
    logic                  out_ready;
    logic [cell_width-1:0] out_sum;

    modport master (
        output in_c, in_ready, out_ack,
        input  in_ack, out_ready, out_sum
    );

    modport slave (
        input  in_c, in_ready, out_ack,
        output in_ack, out_ready, out_sum
    );
endinterface

// File: rtl/column_adder.sv
// column_adder: left-fold FP32 sum of one packed column through a single sequential single_adder.
// Optional macro COLUMN_ADDER_ZERO_SKIP_EN: elements equal to +0/-0 bypass the adder in s_LOAD.
module column_adder #(
    parameter int size       = 4,
    parameter int cell_width = 32,
    parameter int width      = cell_width * size
) (
    input  logic          in_clk,
    input  logic          in_reset,
    column_adder_if.slave bus,
    output logic [1:0]    o_state
);
    localparam int CW = $clog2(size + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [width-1:0]      r_col;
    logic [cell_width-1:0] r_acc;
    logic [cell_width-1:0] r_a;
    logic [cell_width-1:0] r_b;
    logic [CW-1:0]         r_cnt;
    logic                  r_stb;
    logic                  r_z_ack;
    logic                  r_in_ack;
    logic [cell_width-1:0] w_elem;
    logic [cell_width-1:0] w_z;
    logic                  w_z_stb;
    logic                  w_adder_rst;
    logic                  w_last;

    always_comb begin
        w_elem = '0;
        for (int k = 0; k < size; k++) begin
            if (r_cnt == CW'(k)) w_elem = r_col[k*cell_width +: cell_width];
        end
    end

    assign w_last = (r_cnt == CW'(size));

`ifdef COLUMN_ADDER_ZERO_SKIP_EN
    logic w_skip;
    // Sign bit ignored: both +0 and -0 leave the accumulator untouched, so the sum keeps e0's sign.
    assign w_skip = (w_elem[cell_width-2:0] == '0);
`endif

    always_ff @(posedge in_clk) begin
        if (in_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_ready) w_next = S_LOAD;
            S_LOAD: begin
                if (w_last) w_next = S_DONE;
`ifdef COLUMN_ADDER_ZERO_SKIP_EN
                else if (w_skip) w_next = S_LOAD;
`endif
                else w_next = S_ADD;
            end
            S_ADD:  if (w_z_stb) w_next = S_LOAD;
            S_DONE: if (bus.out_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_ready = (r_state == S_DONE);
        bus.out_sum   = (r_state == S_DONE) ? r_acc : '0;
        bus.in_ack    = r_in_ack;
        // Adder held in reset while idle and during our own reset, so a pending result is dropped.
        w_adder_rst   = in_reset || (r_state == S_IDLE);
        o_state       = r_state;
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_col    <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_stb    <= 1'b0;
            r_z_ack  <= 1'b0;
            r_in_ack <= 1'b0;
        end else begin
            r_in_ack <= 1'b0;
            r_z_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_ready) begin
                        r_col    <= bus.in_c;
                        r_acc    <= bus.in_c[cell_width-1:0];
                        r_cnt    <= CW'(1);
                        r_in_ack <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!w_last) begin
`ifdef COLUMN_ADDER_ZERO_SKIP_EN
                        if (w_skip) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_a   <= r_acc;
                            r_b   <= w_elem;
                            r_stb <= 1'b1;
                        end
`else
                        r_a   <= r_acc;
                        r_b   <= w_elem;
                        r_stb <= 1'b1;
`endif
                    end
                end
                S_ADD: begin
                    if (w_z_stb) begin
                        r_acc   <= w_z;
                        r_z_ack <= 1'b1;
                        r_stb   <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    single_adder u_adder (
        .clk          (in_clk),
        .rst          (w_adder_rst),
        .input_a      (r_a),
        .input_b      (r_b),
        .input_a_stb  (r_stb),
        .input_b_stb  (r_stb),
        .output_z_ack (r_z_ack),
        .output_z     (w_z),
        .output_z_stb (w_z_stb)
    );
endmodule

// FP32 adder, round-to-nearest-even, one-cycle latency; result held until output_z_ack.
module single_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        input_a_stb,
    input  logic        input_b_stb,
    input  logic        output_z_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb
);
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] l, s;
        logic [9:0]  el, es, e, d;
        logic [26:0] ml, ms, m;
        logic [53:0] sh;
        logic [27:0] sum;
        logic [24:0] rm;
        logic        rup;
        fp_add = 32'h0;
        if ((a[30:23] == 8'hff && a[22:0] != 23'h0) || (b[30:23] == 8'hff && b[22:0] != 23'h0)) begin
            fp_add = 32'h7fc00000;
        end else if (a[30:23] == 8'hff && b[30:23] == 8'hff) begin
            fp_add = (a[31] != b[31]) ? 32'h7fc00000 : a;
        end else if (a[30:23] == 8'hff) begin
            fp_add = a;
        end else if (b[30:23] == 8'hff) begin
            fp_add = b;
        end else begin
            if (a[30:0] >= b[30:0]) begin l = a; s = b; end
            else                    begin l = b; s = a; end
            el = (l[30:23] == 8'h0) ? 10'd1 : {2'b00, l[30:23]};
            es = (s[30:23] == 8'h0) ? 10'd1 : {2'b00, s[30:23]};
            ml = {(l[30:23] != 8'h0), l[22:0], 3'b000};
            ms = {(s[30:23] != 8'h0), s[22:0], 3'b000};
            // Alignment keeps guard/round bits plus a sticky bit collecting everything shifted past them.
            d  = ((el - es) > 10'd27) ? 10'd27 : (el - es);
            sh = {ms, 27'h0} >> d;
            ms = sh[53:27] | {26'h0, |sh[26:0]};
            e  = el;
            if (l[31] == s[31]) begin
                sum = {1'b0, ml} + {1'b0, ms};
                if (sum[27]) begin
                    m = sum[27:1] | {26'h0, sum[0]};
                    e = el + 10'd1;
                end else begin
                    m = sum[26:0];
                end
            end else begin
                m = ml - ms;
                for (int i = 0; i < 26; i++) begin
                    if (!m[26] && e > 10'd1) begin
                        m = m << 1;
                        e = e - 10'd1;
                    end
                end
            end
            rup = m[2] & (m[1] | m[0] | m[3]);
            rm  = {1'b0, m[26:3]} + {24'h0, rup};
            if (rm[24]) begin
                rm = rm >> 1;
                e  = e + 10'd1;
            end
            if (m == 27'h0)        fp_add = (l[31] & s[31]) ? 32'h80000000 : 32'h0;
            else if (e >= 10'd255) fp_add = {l[31], 8'hff, 23'h0};
            else                   fp_add = {l[31], (rm[23] ? e[7:0] : 8'h00), rm[22:0]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            output_z     <= 32'h0;
            output_z_stb <= 1'b0;
        end else if (output_z_stb) begin
            if (output_z_ack) output_z_stb <= 1'b0;
        end else if (input_a_stb && input_b_stb) begin
            output_z     <= fp_add(input_a, input_b);
            output_z_stb <= 1'b1;
        end
    end
endmodule

// File: tb/tb_column_adder.sv
// Bench for column_adder: directed FP32 columns, handshake corner cases and random integer-valued columns.
module tb_column_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    column_adder_if #(.size(4)) bus ();
    column_adder_if #(.size(1)) bus1 ();
    logic [1:0] st;
    logic [1:0] st1;

    column_adder #(.size(4)) dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus),
        .o_state  (st)
    );

    column_adder #(.size(1)) dut1 (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus1),
        .o_state  (st1)
    );

    int n_pass = 0;
    int n_total = 0;
    int in_ack_cnt = 0;
    int add_cnt = 0;
    int add1_stb = 0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.in_ack) in_ack_cnt++;
        if (dut.r_z_ack) add_cnt++;
        if (dut1.r_stb) add1_stb++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [31:0] e0, input logic [31:0] e1,
                                        input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Exact FP32 encoding for integers below 2^24 in magnitude.
    function automatic logic [31:0] i2f(input int v);
        int a;
        int msb;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        msb = 0;
        for (int i = 0; i < 24; i++) if (a[i]) msb = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + msb);
        r[22:0]  = 23'((a << (23 - msb)) & 32'h7fffff);
        return r;
    endfunction

    task automatic send_col(input logic [127:0] col, input logic [31:0] exp_v,
                            output logic ok, output int n);
        exp_q.push_back(exp_v);
        bus.in_c = col;
        bus.in_ready = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            tick;
            n++;
            if (bus.in_ack) ok = 1'b1;
        end
        bus.in_ready = 1'b0;
    endtask

    task automatic wait_out(output logic ok, output logic [31:0] sum, output int n);
        n = 0;
        while (!bus.out_ready && n < 300) begin
            tick;
            n++;
        end
        ok = bus.out_ready;
        sum = bus.out_sum;
    endtask

    task automatic ack_out;
        bus.out_ack = 1'b1;
        tick;
        bus.out_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_c = '0; bus.in_ready = 1'b0; bus.out_ack = 1'b0;
        bus1.in_c = '0; bus1.in_ready = 1'b0; bus1.out_ack = 1'b0;
        repeat (3) tick;
        n_total++;
        if (bus.out_ready !== 1'b0) $display("FAIL reset_out_ready got=%b want=0", bus.out_ready);
        else n_pass++;
        n_total++;
        if (bus.out_sum !== 32'h0) $display("FAIL reset_out_sum got=%h want=00000000", bus.out_sum);
        else n_pass++;
        n_total++;
        if (st !== 2'd0) $display("FAIL reset_state got=%0d want=0", st);
        else n_pass++;
        bus.in_c = mk(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
        bus.in_ready = 1'b1;
        bus.out_ack = 1'b1;
        tick;
        tick;
        n_total++;
        if (bus.in_ack !== 1'b0 || st !== 2'd0)
            $display("FAIL reset_priority got in_ack=%b state=%0d want in_ack=0 state=0", bus.in_ack, st);
        else n_pass++;
        bus.in_ready = 1'b0;
        bus.out_ack = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_all_ones;
        logic ok1, ok2;
        int n1, n2, a0;
        logic [31:0] s, e;
        a0 = in_ack_cnt;
        send_col(mk(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000), 32'h40800000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!(ok1 && ok2)) $display("FAIL ones_timeout got ack=%b ready=%b want 1/1", ok1, ok2);
        else n_pass++;
        n_total++;
        if (s !== e) $display("FAIL ones_sum got=%h want=%h", s, e);
        else n_pass++;
        n_total++;
        if (in_ack_cnt - a0 != 1) $display("FAIL ones_in_ack_pulses got=%0d want=1", in_ack_cnt - a0);
        else n_pass++;
        n_total++;
        if (n1 + n2 != 11) $display("FAIL ones_latency got=%0d want=11", n1 + n2);
        else n_pass++;
        ack_out;
        n_total++;
        if (bus.out_ready !== 1'b0) $display("FAIL ones_release got=%b want=0", bus.out_ready);
        else n_pass++;
    endtask

    task automatic test_hold;
        logic ok1, ok2, stable;
        int n1, n2;
        logic [31:0] s, e;
        send_col(mk(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000), 32'h41200000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL hold_sum got=%h ready=%b want=%h", s, ok2, e);
        else n_pass++;
        stable = 1'b1;
        repeat (5) begin
            tick;
            if (bus.out_ready !== 1'b1 || bus.out_sum !== e) stable = 1'b0;
        end
        n_total++;
        if (!stable) $display("FAIL hold_stable got ready=%b sum=%h want 1/%h", bus.out_ready, bus.out_sum, e);
        else n_pass++;
        ack_out;
        n_total++;
        if (bus.out_ready !== 1'b0) $display("FAIL hold_release got=%b want=0", bus.out_ready);
        else n_pass++;
    endtask

    task automatic test_ignore_in_ready;
        logic ok1, ok2;
        int n1, n2, n, a0;
        logic [31:0] s, e;
        send_col(mk(32'h3f800000, 32'hbf800000, 32'h40000000, 32'hc0000000), 32'h00000000, ok1, n1);
        n = 0;
        while (st !== 2'd2 && n < 50) begin tick; n++; end
        a0 = in_ack_cnt;
        bus.in_c = mk(32'h42000000, 32'h42000000, 32'h42000000, 32'h42000000);
        bus.in_ready = 1'b1;
        bus.out_ack = 1'b1;
        tick;
        bus.in_ready = 1'b0;
        bus.out_ack = 1'b0;
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (in_ack_cnt != a0) $display("FAIL ignore_in_ack got=%0d extra pulses want=0", in_ack_cnt - a0);
        else n_pass++;
        n_total++;
        if (!ok2 || s !== e) $display("FAIL ignore_sum got=%h ready=%b want=%h", s, ok2, e);
        else n_pass++;
        ack_out;
    endtask

    task automatic test_reset_mid_add;
        logic ok1, ok2, seen;
        int n1, n2, n;
        logic [31:0] s, e;
        send_col(mk(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000), 32'h41200000, ok1, n1);
        n = 0;
        while (!(st == 2'd2 && dut.r_cnt == 2) && n < 100) begin tick; n++; end
        n_total++;
        if (n >= 100) $display("FAIL midreset_reach_add got timeout want second add");
        else n_pass++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        void'(exp_q.pop_back());
        n_total++;
        if (bus.out_ready !== 1'b0 || bus.out_sum !== 32'h0 || st !== 2'd0)
            $display("FAIL midreset_state got ready=%b sum=%h st=%0d want 0/00000000/0",
                     bus.out_ready, bus.out_sum, st);
        else n_pass++;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (bus.out_ready) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL midreset_discard got out_ready=1 want 0");
        else n_pass++;
        send_col(mk(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000), 32'h41200000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL midreset_resend got=%h ready=%b want=%h", s, ok2, e);
        else n_pass++;
        ack_out;
    endtask

    task automatic test_size1;
        int n, b0;
        logic [31:0] e;
        b0 = add1_stb;
        exp_q.push_back(32'h40490fdb);
        bus1.in_c = 32'h40490fdb;
        bus1.in_ready = 1'b1;
        n = 0;
        while (!bus1.out_ready && n < 50) begin
            tick;
            n++;
            if (bus1.in_ack) bus1.in_ready = 1'b0;
        end
        bus1.in_ready = 1'b0;
        e = exp_q.pop_front();
        n_total++;
        if (!bus1.out_ready || bus1.out_sum !== e)
            $display("FAIL size1_sum got=%h ready=%b want=%h", bus1.out_sum, bus1.out_ready, e);
        else n_pass++;
        n_total++;
        if (n != 2) $display("FAIL size1_latency got=%0d want=2", n);
        else n_pass++;
        n_total++;
        if (add1_stb != b0) $display("FAIL size1_adder_stb got=%0d want=0", add1_stb - b0);
        else n_pass++;
        bus1.out_ack = 1'b1;
        tick;
        bus1.out_ack = 1'b0;
        n_total++;
        if (bus1.out_ready !== 1'b0) $display("FAIL size1_release got=%b want=0", bus1.out_ready);
        else n_pass++;
    endtask

    task automatic test_zero_skip;
        logic ok1, ok2;
        int n1, n2, a0, want;
        logic [31:0] s, e;
`ifdef COLUMN_ADDER_ZERO_SKIP_EN
        want = 1;
`else
        want = 3;
`endif
        a0 = add_cnt;
        send_col(mk(32'h00000000, 32'h00000000, 32'h80000000, 32'h40400000), 32'h40400000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL zero_sum got=%h ready=%b want=%h", s, ok2, e);
        else n_pass++;
        n_total++;
        if (add_cnt - a0 != want) $display("FAIL zero_adds got=%0d want=%0d", add_cnt - a0, want);
        else n_pass++;
        ack_out;
    endtask

    task automatic test_rounding;
        logic ok1, ok2;
        int n1, n2;
        logic [31:0] s, e;
        send_col(mk(32'h3f800001, 32'h33800000, 32'h0, 32'h0), 32'h3f800002, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL round_tie_up got=%h want=%h", s, e);
        else n_pass++;
        ack_out;
        send_col(mk(32'h3f800000, 32'h33800000, 32'h33800000, 32'h33800000), 32'h3f800000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL round_tie_even got=%h want=%h", s, e);
        else n_pass++;
        ack_out;
    endtask

    task automatic test_back_to_back;
        logic ok1, ok2;
        int n1, n2;
        logic [31:0] s, e;
        send_col(mk(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000), 32'h40800000, ok1, n1);
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL b2b_first got=%h want=%h", s, e);
        else n_pass++;
        exp_q.push_back(32'h41000000);
        bus.in_c = mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        bus.in_ready = 1'b1;
        bus.out_ack = 1'b1;
        tick;
        bus.out_ack = 1'b0;
        n_total++;
        if (bus.out_ready !== 1'b0 || bus.in_ack !== 1'b0)
            $display("FAIL b2b_exit_first got ready=%b in_ack=%b want 0/0", bus.out_ready, bus.in_ack);
        else n_pass++;
        tick;
        n_total++;
        if (bus.in_ack !== 1'b1) $display("FAIL b2b_capture got in_ack=%b want=1", bus.in_ack);
        else n_pass++;
        bus.in_ready = 1'b0;
        wait_out(ok2, s, n2);
        e = exp_q.pop_front();
        n_total++;
        if (!ok2 || s !== e) $display("FAIL b2b_second got=%h want=%h", s, e);
        else n_pass++;
        ack_out;
    endtask

    task automatic test_random;
        logic ok1, ok2;
        int n1, n2, tot;
        int v[4];
        logic [31:0] s, e;
        for (int it = 0; it < 10; it++) begin
            tot = 0;
            for (int k = 0; k < 4; k++) begin
                v[k] = int'($urandom_range(2000)) - 1000;
                tot += v[k];
            end
            send_col(mk(i2f(v[0]), i2f(v[1]), i2f(v[2]), i2f(v[3])), i2f(tot), ok1, n1);
            wait_out(ok2, s, n2);
            e = exp_q.pop_front();
            n_total++;
            if (!ok2 || s !== e)
                $display("FAIL random_%0d got=%h want=%h (%0d %0d %0d %0d)", it, s, e, v[0], v[1], v[2], v[3]);
            else n_pass++;
            repeat ($urandom_range(3)) tick;
            ack_out;
            repeat ($urandom_range(2)) tick;
        end
    endtask

    initial begin
        test_reset;
        test_all_ones;
        test_hold;
        test_ignore_in_ready;
        test_reset_mid_add;
        test_size1;
        test_zero_skip;
        test_rounding;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
